// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot/run program loader: state encoding and link control bytes.
package program_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StData,
        StFlush,
        StRun
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] HALT_BYTE = 8'h5A;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs an MSB-first byte stream into 32-bit words and watches the gap between bytes.
// word_ready, word and timeout are combinational so the owner can register them on the same edge.
module program_loader_word_assembler #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_ready,
    output logic [31:0] word,
    output logic        timeout
);

    localparam int unsigned GAP_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_WIDTH-1:0] GAP_LAST = GAP_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [23:0]          shift_q, shift_d;
    logic [1:0]           index_q, index_d;
    logic [GAP_WIDTH-1:0] gap_q, gap_d;

    // Strobes must not depend on clear: the owner derives clear from them.
    assign word       = {shift_q, byte_data};
    assign word_ready = enable && byte_valid && (index_q == 2'd3);
    assign timeout    = enable && !byte_valid && (gap_q == GAP_LAST);

    always_comb begin
        shift_d = shift_q;
        index_d = index_q;
        gap_d   = gap_q;
        if (clear || !enable) begin
            shift_d = '0;
            index_d = '0;
            gap_d   = '0;
        end else if (byte_valid) begin
            shift_d = word[23:0];
            index_d = index_q + 2'd1;
            gap_d   = '0;
        end else if (gap_q != GAP_LAST) begin
            gap_d = gap_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            shift_q <= '0;
            index_q <= '0;
            gap_q   <= '0;
        end else begin
            shift_q <= shift_d;
            index_q <= index_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot/run controller: holds the processor in reset while a host streams a program over the
// byte link, writes it to instruction memory, then releases the processor until HALT.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  processor_reset,
    output logic                  imem_write_enable,
    output logic [ADDR_WIDTH-1:0] imem_write_address,
    output logic [31:0]           imem_write_data,
    output logic                  loading,
    output logic                  running,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;
    localparam int unsigned HOLD_WIDTH = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [ADDR_WIDTH:0]     words_q, words_d;
    logic [HOLD_WIDTH-1:0]   hold_q, hold_d;
    logic                    error_q, error_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    prst_q, loading_q, running_q;

    logic        asm_clear, asm_enable, word_ready, timeout;
    logic [31:0] word;

    assign asm_enable = (state_q == StCount) || (state_q == StData);

    program_loader_word_assembler #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_word_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (asm_clear),
        .enable     (asm_enable),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .word_ready (word_ready),
        .word       (word),
        .timeout    (timeout)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        words_d   = words_q;
        hold_d    = hold_q;
        error_d   = error_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        asm_clear = 1'b0;

        case (state_q)
            StIdle: begin
                if (byte_valid && byte_data == SYNC_BYTE) begin
                    state_d   = StCount;
                    error_d   = 1'b0;
                    words_d   = '0;
                    asm_clear = 1'b1;
                end
            end
            StCount: begin
                if (timeout) begin
                    state_d   = StIdle;
                    error_d   = 1'b1;
                    asm_clear = 1'b1;
                end else if (word_ready) begin
                    if (word == 32'd0 || {1'b0, word} > DEPTH) begin
                        state_d   = StIdle;
                        error_d   = 1'b1;
                        asm_clear = 1'b1;
                    end else begin
                        // Range check above guarantees N fits in ADDR_WIDTH+1 bits.
                        count_d = word[ADDR_WIDTH:0];
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (timeout) begin
                    state_d   = StIdle;
                    error_d   = 1'b1;
                    asm_clear = 1'b1;
                end else if (word_ready) begin
                    we_d    = 1'b1;
                    waddr_d = words_q[ADDR_WIDTH-1:0];
                    wdata_d = word;
                    words_d = words_q + 1'b1;
                    if (words_d == count_q) begin
                        state_d = StFlush;
                        hold_d  = '0;
                    end
                end
            end
            StFlush: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StRun: begin
                if (byte_valid && byte_data == HALT_BYTE) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StIdle;
            count_q   <= '0;
            words_q   <= '0;
            hold_q    <= '0;
            error_q   <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            prst_q    <= 1'b1;
            loading_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            words_q   <= words_d;
            hold_q    <= hold_d;
            error_q   <= error_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            // Status flags follow the next state so they line up with state_q.
            prst_q    <= (state_d != StRun);
            loading_q <= (state_d == StCount) || (state_d == StData) || (state_d == StFlush);
            running_q <= (state_d == StRun);
        end
    end

    assign processor_reset    = prst_q;
    assign imem_write_enable  = we_q;
    assign imem_write_address = waddr_q;
    assign imem_write_data    = wdata_q;
    assign loading            = loading_q;
    assign running            = running_q;
    assign error              = error_q;
    assign words_loaded       = words_q;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot and run controller for the pipelined processor.
- Holds the processor in reset while a host streams a program over a byte link (UART receiver output), then releases it.
- Assembles bytes into 32-bit words and writes them into instruction memory through a dedicated write port.
- Sits between the UART receiver, the instruction memory write port and the processor's reset input.

Parameters:
ADDR_WIDTH, 10, instruction memory word-address width; depth = 2^ADDR_WIDTH words
HOLD_CYCLES, 4, cycles processor_reset stays high after the last word is written; must be >= 1
TIMEOUT_CYCLES, 1000000, maximum idle gap between bytes inside a count or word before the load aborts

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset (0 = reset asserted)
byte_valid  input  1  one-cycle strobe: byte_data is valid; no backpressure
byte_data  input  8  received byte
processor_reset  output  1  active-high reset to the processor (matches processor polarity)
imem_write_enable  output  1  one-cycle instruction memory write strobe
imem_write_address  output  ADDR_WIDTH  word address of the write
imem_write_data  output  32  instruction word
loading  output  1  high in COUNT, DATA or FLUSH
running  output  1  high in RUN
error  output  1  sticky load-failure flag
words_loaded  output  ADDR_WIDTH+1  number of words written in the current or last load

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE.
  - processor_reset=1, imem_write_enable=0, imem_write_address=0, imem_write_data=0.
  - loading=0, running=0, error=0, words_loaded=0.
  - Byte and timeout counters clear.
  - Reset mid-load abandons the load. Words already written stay in memory.
- All outputs are registered.
- IDLE: processor_reset=1. A byte 8'hA5 (SYNC) moves to COUNT and clears error, words_loaded and the byte counter. All other bytes are ignored.
- COUNT: collects 4 bytes, MSB first, into a 32-bit count N.
  - On the 4th byte, if N==0 or N>2^ADDR_WIDTH: error=1, go to IDLE.
  - Otherwise go to DATA with the address at 0.
- DATA: collects 4 bytes per word, MSB first.
  - The 4th byte of a word arrives at cycle t. At t+1: imem_write_enable=1, imem_write_address=current address, imem_write_data=word, words_loaded increments, address increments.
  - After word N is written, the state is FLUSH at t+1, concurrent with the final write strobe.
- FLUSH: processor_reset=1 for exactly HOLD_CYCLES cycles, counting from t+1. Bytes are ignored.
- RUN: entered after FLUSH completes; processor_reset=0 in the first RUN cycle.
  - A byte 8'h5A (HALT) gives processor_reset=1 and state IDLE on the next cycle.
  - Other bytes are ignored.
  - A SYNC byte in RUN is ignored; the host must HALT first.
- Timeout:
  - In COUNT or DATA, the gap counter resets on every byte_valid.
  - When the counter reaches TIMEOUT_CYCLES with no byte: error=1, go to IDLE. A partial word is not written.
  - If byte_valid arrives in the same cycle as the expiry, the byte wins: it is accepted and the counter clears.
- Address wrap cannot occur: N is bounded by the depth. N = 2^ADDR_WIDTH exactly is legal, and words_loaded reaches 2^ADDR_WIDTH.
- imem_write_enable is never high outside DATA→FLUSH transitions and DATA word completions. processor_reset is never low while imem_write_enable is high.

Decomposition:
- Shared package: state encoding (IDLE, COUNT, DATA, FLUSH, RUN), SYNC_BYTE=8'hA5, HALT_BYTE=8'h5A.
- Sub-module word_assembler:
  - Behaviour: 4-byte MSB-first shift register, byte index, inter-byte timeout counter.
  - Outputs: word_ready strobe, 32-bit word and timeout strobe.
  - Cleared by the FSM on SYNC or abort.
- The FSM, address and words_loaded counter, and flush counter stay in program_loader.

Test Plan:
1. Reset, then bytes A5, 00 00 00 02, 11 22 33 44, AA BB CC DD → writes (0,11223344) and (1,AABBCCDD), each 1 cycle after its 4th byte. words_loaded=2. processor_reset falls exactly HOLD_CYCLES cycles after the second write strobe. running=1.
2. In RUN, send 5A → processor_reset=1 and running=0 on the next cycle. A following A5 begins a new load with error=0.
3. A5 then count 00 00 00 00, and separately count 2^ADDR_WIDTH+1 → error=1, no write strobes, state IDLE, processor_reset=1.
4. A5, count 1, then bytes 12 34 and silence for TIMEOUT_CYCLES → error=1, IDLE, no write. Repeat with the 3rd byte landing on the expiry cycle → byte accepted, no error.
5. Drive reset=0 in the middle of DATA after 1 of 3 words → all outputs at reset values next cycle. A full reload then succeeds.
6. Full-depth load of 2^ADDR_WIDTH words of address-valued data → last write at address 2^ADDR_WIDTH-1, words_loaded=2^ADDR_WIDTH, no extra strobe.
